pc_controller: RTL and testbench
================================

Name: pc_controller

Overview:
- Sequencing controller for the 16-bit program counter (the block taking `pc_op_i`/`pc_i` and producing `pc_o`/`pcinc_o`).
- Drives the counter's `pc_op_i` and `pc_i` through a fetch/execute FSM.
- Handshakes with instruction fetch.
- Resolves branch, call and return requests.
- Keeps a hardware return-address stack of depth PROFUNDIDAD.
- Instantiated next to the program counter in the top level; its `pcinc_o` feeds back into this block.

Parameters:
- ANCHO, 16, address width; must equal the program counter's ANCHO.
- PROFUNDIDAD, 4, return-stack entries (≥2).

Ports:
- clk_i  in  1  single system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_valid_i  in  1  fetched instruction and its decode flags are valid this cycle.
- stall_i  in  1  downstream not ready; blocks acceptance.
- branch_i  in  1  accepted instruction is a taken branch/jump.
- call_i  in  1  accepted instruction is a call.
- ret_i  in  1  accepted instruction is a return.
- target_i  in  ANCHO  branch/call destination.
- pcinc_i  in  ANCHO  return address, from the program counter's `pcinc_o`.
- pc_op_o  out  2  to the counter's `pc_op_i`.
- pc_target_o  out  ANCHO  to the counter's `pc_i`.
- fetch_req_o  out  1  controller waiting for an instruction.
- stack_level_o  out  $clog2(PROFUNDIDAD+1)  stack occupancy.
- error_o  out  1  sticky stack fault.

Behaviour:
- pc_op encoding:
  - 00 = clear PC to 0
  - 01 = hold
  - 10 = increment (PC ← pcinc)
  - 11 = load `pc_i`
- All outputs decode from registered state/target only; no input→output combinational path.
- States:
  - S_RESET: pc_op_o=00, fetch_req_o=0. Next state S_FETCH.
  - S_FETCH: pc_op_o=01, fetch_req_o=1. On accept (`instr_valid_i & ~stall_i`): register the decision and go to S_EXEC. Otherwise stay.
  - S_EXEC: pc_op_o = registered op, for exactly one cycle. Next state S_FETCH, or S_HALT on a fault.
  - S_HALT: pc_op_o=01, fetch_req_o=0, error_o=1. Leaves only via rst_i.
- Decision priority at accept: ret_i > call_i > branch_i > none.
  - ret: pop; pc_target_o ← top entry; op=11.
  - call: push `pcinc_i` sampled at the accept cycle; pc_target_o ← target_i; op=11.
  - branch: pc_target_o ← target_i; op=11.
  - none: op=10; pc_target_o holds its previous value.
- Latency: accept at cycle N → pc_op_o valid at N+1 → counter's pc_o updated after the N+1 edge (visible at N+2). Back-to-back instructions need ≥2 cycles each.
- Stack: LIFO; push/pop take effect at the accept edge; stack_level_o updates the same edge.
- Faults:
  - call with level=PROFUNDIDAD → overflow: no push, S_HALT.
  - ret with level=0 → underflow: no pop, S_HALT.
  - Fault is detected at accept; the next cycle is S_HALT, so no op=11 is ever issued for a faulting instruction.
- stall_i high, or instr_valid_i low, in S_FETCH → no state change; pc_op_o stays 01.
- Decode flags are ignored outside the S_FETCH accept cycle.
- Reset: rst_i high at any edge, including mid-S_EXEC or in S_HALT, takes effect that edge:
  - state=S_RESET, pc_op_o=00, pc_target_o=0, fetch_req_o=0, stack_level_o=0, error_o=0.
  - While rst_i is held, the block stays in S_RESET.
  - First S_FETCH is the cycle after the first edge with rst_i low.
- Widths: all addresses are ANCHO bits; no arithmetic is performed here (the increment lives in the counter).

Test Plan:
- Reset: hold rst_i 3 cycles → pc_op_o=00, fetch_req_o=0, error_o=0. Release → S_FETCH next cycle, pc_op_o=01, fetch_req_o=1.
- Sequential: 4 plain instructions, each accepted with instr_valid_i=1 on first assertion → each produces one cycle of pc_op_o=10. Counter pc_o steps 0→4→8→C→10 (counter increments by 4).
- Stall: instr_valid_i=1 with stall_i=1 for 5 cycles → pc_op_o stays 01, no accept. Drop stall_i → pc_op_o=10 on the following cycle.
- Call/ret: at PC=0x0008, call target_i=0x0100 → pc_target_o=0x0100, op=11, stack_level_o=1. Later ret → pc_target_o=0x000C, op=11, stack_level_o=0.
- Priority: ret_i, call_i and branch_i all high, stack holding 0x0040 → pop only, pc_target_o=0x0040, stack_level_o decrements by 1.
- Faults:
  - 5 calls with PROFUNDIDAD=4 → 5th enters S_HALT, error_o=1, stack_level_o=4, pc_op_o=01.
  - rst_i → error_o=0.
  - ret on an empty stack → S_HALT.

Source files
------------

// File: rtl/pc_controller.sv
// -----------------------------------------------------------------------------
// pc_controller
//   Sequencing controller for the program counter. A fetch/execute FSM accepts
//   one instruction at a time from instruction fetch, resolves
//   branch/call/return requests, and drives the counter's operation and load
//   value for one cycle per instruction. Return addresses are kept on a small
//   hardware LIFO. A stack overflow or underflow parks the block in a halt
//   state that only rst_i can leave.
//
//   Handshake: an instruction is accepted on a rising edge where the FSM is in
//   S_FETCH (fetch_req_o=1), instr_valid_i=1 and stall_i=0. The decode flags and
//   target_i/pcinc_i are sampled only on that edge and ignored at all other
//   times. Each accepted instruction is followed by exactly one S_EXEC cycle.
//
//   pc_op_o encoding: 00 clear, 01 hold, 10 increment, 11 load pc_i.
//
// Ports
//   clk_i          in   system clock, rising edge
//   rst_i          in   synchronous active-high reset
//   instr_valid_i  in   fetched instruction and decode flags valid
//   stall_i        in   downstream not ready, blocks acceptance
//   branch_i       in   accepted instruction is a taken branch/jump
//   call_i         in   accepted instruction is a call
//   ret_i          in   accepted instruction is a return
//   target_i       in   branch/call destination
//   pcinc_i        in   return address (counter's pcinc_o)
//   pc_op_o        out  operation for the counter
//   pc_target_o    out  load value for the counter
//   fetch_req_o    out  controller waiting for an instruction
//   stack_level_o  out  return-stack occupancy
//   error_o        out  sticky stack fault (high while halted)
//   dbg_state_o    out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module pc_controller #(
  parameter int ANCHO       = 16,
  parameter int PROFUNDIDAD = 4,
  localparam int LW         = $clog2(PROFUNDIDAD + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [ANCHO-1:0] target_i,
  input  logic [ANCHO-1:0] pcinc_i,
  output logic [1:0]       pc_op_o,
  output logic [ANCHO-1:0] pc_target_o,
  output logic             fetch_req_o,
  output logic [LW-1:0]    stack_level_o,
  output logic             error_o,
  output logic [1:0]       dbg_state_o
);

  localparam int IW = $clog2(PROFUNDIDAD);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_HOLD  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [LW-1:0] LVL_FULL = LW'(PROFUNDIDAD);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic [ANCHO-1:0] r_target;
  logic [ANCHO-1:0] w_target_nxt;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic [ANCHO-1:0] r_stack [PROFUNDIDAD];

  logic             w_accept;
  logic             w_push;
  logic             w_fault;
  logic [LW-1:0]    w_level_dec;
  logic [LW-1:0]    w_level_inc;
  logic [IW-1:0]    w_push_idx;
  logic [IW-1:0]    w_top_idx;

  assign w_accept    = (r_state == S_FETCH) && instr_valid_i && !stall_i;
  assign w_level_dec = r_level - LVL_ONE;
  assign w_level_inc = r_level + LVL_ONE;
  // Entry r_level is the next free slot; entry r_level-1 is the top.
  assign w_push_idx  = r_level[IW-1:0];
  assign w_top_idx   = w_level_dec[IW-1:0];

  // ---------------------------------------------------------------------------
  // Decision at accept: ret > call > branch > plain. A faulting instruction
  // leaves target, op and stack untouched; the FSM goes straight to halt so
  // the stale op is never issued.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_push       = 1'b0;
    w_fault      = 1'b0;
    w_op_nxt     = r_op;
    w_target_nxt = r_target;
    w_level_nxt  = r_level;
    if (w_accept) begin
      if (ret_i) begin
        if (r_level == '0) begin
          w_fault = 1'b1;
        end else begin
          w_level_nxt  = w_level_dec;
          w_target_nxt = r_stack[w_top_idx];
          w_op_nxt     = OP_LOAD;
        end
      end else if (call_i) begin
        if (r_level == LVL_FULL) begin
          w_fault = 1'b1;
        end else begin
          w_push       = 1'b1;
          w_level_nxt  = w_level_inc;
          w_target_nxt = target_i;
          w_op_nxt     = OP_LOAD;
        end
      end else if (branch_i) begin
        w_target_nxt = target_i;
        w_op_nxt     = OP_LOAD;
      end else begin
        w_op_nxt     = OP_INC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_accept) begin
          w_state_nxt = w_fault ? S_HALT : S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decode from registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_op_o     = OP_HOLD;
    fetch_req_o = 1'b0;
    error_o     = 1'b0;
    case (r_state)
      S_RESET: pc_op_o = OP_CLEAR;
      S_FETCH: begin
        pc_op_o     = OP_HOLD;
        fetch_req_o = 1'b1;
      end
      S_EXEC:  pc_op_o = r_op;
      S_HALT: begin
        pc_op_o = OP_HOLD;
        error_o = 1'b1;
      end
      default: pc_op_o = OP_HOLD;
    endcase
  end

  assign pc_target_o   = r_target;
  assign stack_level_o = r_level;
  assign dbg_state_o   = r_state;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_RESET;
      r_op     <= OP_CLEAR;
      r_target <= '0;
      r_level  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_target <= w_target_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Stack storage needs no reset: occupancy alone decides which entries are
  // meaningful.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_stack[w_push_idx] <= pcinc_i;
    end
  end

endmodule

// File: tb/tb_pc_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_controller
//   Bench for pc_controller. A directed table walks reset, sequential fetch,
//   stall, call/return, priority and fault cases; a short hand sequence checks
//   the counter stepping; then randomized traffic runs against a behavioural
//   model built on a queue-based return stack. A small model of the program
//   counter (increment by 4) closes the loop by feeding pcinc_i.
// -----------------------------------------------------------------------------
module tb_pc_controller;

  localparam int ANCHO = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Clock / DUT signals
  // ---------------------------------------------------------------------------
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             instr_valid_i = 1'b0;
  logic             stall_i = 1'b0;
  logic             branch_i = 1'b0;
  logic             call_i = 1'b0;
  logic             ret_i = 1'b0;
  logic [ANCHO-1:0] target_i = '0;
  logic [ANCHO-1:0] pcinc_i = '0;
  logic [1:0]       pc_op_o;
  logic [ANCHO-1:0] pc_target_o;
  logic             fetch_req_o;
  logic [LW-1:0]    stack_level_o;
  logic             error_o;
  logic [1:0]       dbg_state_o;

  always #5 clk_i = ~clk_i;

  pc_controller #(.ANCHO(ANCHO), .PROFUNDIDAD(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .target_i      (target_i),
    .pcinc_i       (pcinc_i),
    .pc_op_o       (pc_op_o),
    .pc_target_o   (pc_target_o),
    .fetch_req_o   (fetch_req_o),
    .stack_level_o (stack_level_o),
    .error_o       (error_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Counters, environment and reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [ANCHO-1:0] env_pc = '0;          // program counter model

  bit               m_in_reset = 1'b1;    // one cycle of clear after reset
  bit               m_halt     = 1'b0;
  bit               m_wait     = 1'b0;    // waiting for an instruction
  bit               m_issue    = 1'b0;    // executing the accepted instruction
  logic [1:0]       m_op       = 2'b00;
  logic [ANCHO-1:0] m_target   = '0;
  logic [ANCHO-1:0] m_stack[$];
  logic [ANCHO-1:0] exp_q[$];             // expected load targets, in order

  typedef struct {
    logic             rst;
    logic             valid;
    logic             stall;
    logic             br;
    logic             call;
    logic             ret;
    logic [ANCHO-1:0] tgt;
    logic [1:0]       e_op;
    logic             e_fetch;
    logic [LW-1:0]    e_lvl;
    logic             e_err;
    logic [ANCHO-1:0] e_tgt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, valid, stall, br, call, ret,
                     input logic [ANCHO-1:0] tgt,
                     input logic [1:0] e_op, input logic e_fetch,
                     input int e_lvl, input logic e_err,
                     input logic [ANCHO-1:0] e_tgt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.stall = stall;
    v.br = br; v.call = call; v.ret = ret; v.tgt = tgt;
    v.e_op = e_op; v.e_fetch = e_fetch; v.e_lvl = LW'(e_lvl);
    v.e_err = e_err; v.e_tgt = e_tgt;
    tbl.push_back(v);
  endtask

  // Model transition for one clock edge, from the behavioural rules.
  task automatic model_step(input logic rst, valid, stall, br, call, ret,
                            input logic [ANCHO-1:0] tgt, input logic [ANCHO-1:0] inc);
    if (rst) begin
      m_in_reset = 1'b1; m_halt = 1'b0; m_wait = 1'b0; m_issue = 1'b0;
      m_target = '0;
      m_stack.delete();
      exp_q.delete();
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_wait = 1'b1;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_wait = 1'b1;
    end else if (m_wait && valid && !stall) begin
      m_wait = 1'b0;
      if (ret) begin
        if (m_stack.size() == 0) m_halt = 1'b1;
        else begin
          m_target = m_stack.pop_back();
          m_op = 2'b11; m_issue = 1'b1;
          exp_q.push_back(m_target);
        end
      end else if (call) begin
        if (m_stack.size() == DEPTH) m_halt = 1'b1;
        else begin
          m_stack.push_back(inc);
          m_target = tgt;
          m_op = 2'b11; m_issue = 1'b1;
          exp_q.push_back(m_target);
        end
      end else if (br) begin
        m_target = tgt;
        m_op = 2'b11; m_issue = 1'b1;
        exp_q.push_back(m_target);
      end else begin
        m_op = 2'b10; m_issue = 1'b1;
      end
    end
  endtask

  // Driver: apply inputs, advance one clock, update the counter model from the
  // op that was presented at the edge, then compare outputs with the model.
  task automatic cycle(input logic rst, valid, stall, br, call, ret,
                       input logic [ANCHO-1:0] tgt);
    logic [1:0]       p_op;
    logic [ANCHO-1:0] p_tgt;
    logic [1:0]       e_op;
    rst_i = rst; instr_valid_i = valid; stall_i = stall;
    branch_i = br; call_i = call; ret_i = ret; target_i = tgt;
    pcinc_i = env_pc + 16'd4;
    model_step(rst, valid, stall, br, call, ret, tgt, pcinc_i);
    p_op  = pc_op_o;
    p_tgt = pc_target_o;
    @(posedge clk_i);
    #1;
    case (p_op)
      2'b00:   env_pc = '0;
      2'b10:   env_pc = env_pc + 16'd4;
      2'b11:   env_pc = p_tgt;
      default: env_pc = env_pc;
    endcase
    if (m_in_reset)   e_op = 2'b00;
    else if (m_issue) e_op = m_op;
    else              e_op = 2'b01;
    check("model_op",     32'(pc_op_o),       32'(e_op));
    check("model_fetch",  32'(fetch_req_o),   32'(m_wait));
    check("model_level",  32'(stack_level_o), 32'(m_stack.size()));
    check("model_error",  32'(error_o),       32'(m_halt));
    check("model_target", 32'(pc_target_o),   32'(m_target));
    if (pc_op_o == 2'b11) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_load", 32'(pc_target_o), 32'hFFFF_FFFF);
      end else begin
        check("sb_load_target", 32'(pc_target_o), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // reset held 3 cycles, then release
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0,16'h0, 2'b00,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    // four plain instructions
    for (int i = 0; i < 4; i++) begin
      add(0,1,0,0,0,0,16'h0, 2'b10,0,0,0,16'h0);
      add(0,0,0,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    end
    // stall for 5 cycles, then accept
    for (int i = 0; i < 5; i++) add(0,1,1,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    add(0,1,0,0,0,0,16'h0, 2'b10,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    // reset, then two plain instructions to bring PC to 0x0008
    add(1,0,0,0,0,0,16'h0, 2'b00,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    for (int i = 0; i < 2; i++) begin
      add(0,1,0,0,0,0,16'h0, 2'b10,0,0,0,16'h0);
      add(0,0,0,0,0,0,16'h0, 2'b01,1,0,0,16'h0);
    end
    // call 0x0100 from 0x0008, branch inside, return to 0x000C
    add(0,1,0,0,1,0,16'h0100, 2'b11,0,1,0,16'h0100);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,1,0,16'h0100);
    add(0,1,0,1,0,0,16'h0040, 2'b11,0,1,0,16'h0040);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,1,0,16'h0040);
    add(0,1,0,0,0,1,16'h0,    2'b11,0,0,0,16'h000C);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h000C);
    // priority: push 0x0040 via call at 0x003C, then ret+call+branch together
    add(0,1,0,1,0,0,16'h003C, 2'b11,0,0,0,16'h003C);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h003C);
    add(0,1,0,0,1,0,16'h0200, 2'b11,0,1,0,16'h0200);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,1,0,16'h0200);
    add(0,1,0,1,1,1,16'h0300, 2'b11,0,0,0,16'h0040);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h0040);
    // overflow: four calls fill the stack, the fifth halts
    for (int i = 1; i <= 4; i++) begin
      add(0,1,0,0,1,0,16'h0500, 2'b11,0,i,0,16'h0500);
      add(0,0,0,0,0,0,16'h0,    2'b01,1,i,0,16'h0500);
    end
    add(0,1,0,0,1,0,16'h0600, 2'b01,0,4,1,16'h0500);
    add(0,1,0,0,0,0,16'h0,    2'b01,0,4,1,16'h0500);
    add(1,0,0,0,0,0,16'h0,    2'b00,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h0);
    // underflow
    add(0,1,0,0,0,1,16'h0,    2'b01,0,0,1,16'h0);
    add(1,0,0,0,0,0,16'h0,    2'b00,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h0);
    // reset in the middle of an execute cycle
    add(0,1,0,0,0,0,16'h0,    2'b10,0,0,0,16'h0);
    add(1,0,0,0,0,0,16'h0,    2'b00,0,0,0,16'h0);
    add(0,0,0,0,0,0,16'h0,    2'b01,1,0,0,16'h0);
    // flags ignored without valid, and during execute
    add(0,0,0,0,1,0,16'h0123, 2'b01,1,0,0,16'h0);
    add(0,1,0,1,0,0,16'h0077, 2'b11,0,0,0,16'h0077);
    add(0,1,0,1,1,1,16'h0099, 2'b01,1,0,0,16'h0077);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].stall, tbl[i].br,
            tbl[i].call, tbl[i].ret, tbl[i].tgt);
      check($sformatf("tbl_op[%0d]", i),     32'(pc_op_o),       32'(tbl[i].e_op));
      check($sformatf("tbl_fetch[%0d]", i),  32'(fetch_req_o),   32'(tbl[i].e_fetch));
      check($sformatf("tbl_level[%0d]", i),  32'(stack_level_o), 32'(tbl[i].e_lvl));
      check($sformatf("tbl_error[%0d]", i),  32'(error_o),       32'(tbl[i].e_err));
      check($sformatf("tbl_target[%0d]", i), 32'(pc_target_o),   32'(tbl[i].e_tgt));
    end

    // counter stepping: reset, one plain instruction, PC reaches 4
    cycle(1,0,0,0,0,0,16'h0);
    cycle(1,0,0,0,0,0,16'h0);
    check("pc_after_reset", 32'(env_pc), 32'h0);
    cycle(0,0,0,0,0,0,16'h0);
    cycle(0,1,0,0,0,0,16'h0);
    cycle(0,0,0,0,0,0,16'h0);
    check("pc_step", 32'(env_pc), 32'h4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            16'($urandom));
    end

    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
